// File: rtl/decode_execute_reg.sv
// decode_execute_reg: decode->execute pipeline register with 2-entry skid buffer, flush and stall counter
// Ports:
//    clk, rst (async, active-high)
//    in_valid/in_ready + in_data1, in_data2, in_immediate_data, in_control,
//       in_compflg, in_program_counter : decode-side handshake and payload
//    flush : drop every held and incoming instruction
//    out_valid/out_ready + data1, data2, immediate_data, control_in,
//       compflg_in, program_counter : execute-side handshake and payload
//    stall_cycles : saturating count of cycles with out_valid && !out_ready
module decode_execute_reg #(
   parameter int CTRL_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data1,
   input  logic [31:0]       in_data2,
   input  logic [31:0]       in_immediate_data,
   input  logic [CTRL_W-1:0] in_control,
   input  logic              in_compflg,
   input  logic [31:0]       in_program_counter,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       data1,
   output logic [31:0]       data2,
   output logic [31:0]       immediate_data,
   output logic [31:0]       program_counter,
   output logic [CTRL_W-1:0] control_in,
   output logic              compflg_in,
   output logic [CNT_W-1:0]  stall_cycles
);
   localparam int PW = 4 * 32 + 1 + CTRL_W;
   logic [PW-1:0]    out_q, out_d, skid_q, skid_d, in_pl;
   logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             in_fire, out_fire;
   assign in_ready = !skid_valid_q;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;
   // control word sits in the low bits so a flush can zero it with one slice
   assign in_pl = {in_data1, in_data2, in_immediate_data, in_program_counter, in_compflg, in_control};
   assign {data1, data2, immediate_data, program_counter, compflg_in, control_in} = out_q;
   assign out_valid    = out_valid_q;
   assign stall_cycles = stall_q;
   assign stall_d = (out_valid_q && !out_ready && stall_q != {CNT_W{1'b1}}) ? stall_q + CNT_W'(1) : stall_q;
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         out_d        = {out_q[PW-1:CTRL_W], {CTRL_W{1'b0}}};
      end else if (skid_valid_q) begin
         if (out_fire) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (out_valid_q && !out_fire) begin
         // output held: a new instruction parks behind it in the skid slot
         if (in_fire) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
         end
      end else begin
         // empty, or the held instruction leaves this cycle
         out_valid_d = in_fire;
         if (in_fire) out_d = in_pl;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         stall_q      <= stall_d;
      end
   end
endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg: directed and random checks of decode_execute_reg against a queue model
module tb_decode_execute_reg;
   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] ctrl;
      logic        cf;
   } instr_t;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   instr_t cur = '0;
   logic in_ready, out_valid, compflg_in;
   logic [31:0] data1, data2, immediate_data, program_counter, control_in;
   logic [15:0] stall16;
   logic ir4, ov4, cf4;
   logic [31:0] d1_4, d2_4, imm_4, pc4, ctrl4;
   logic [3:0] stall4;
   instr_t q[$];
   int cnt = 0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   decode_execute_reg dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data1(cur.d1), .in_data2(cur.d2), .in_immediate_data(cur.imm),
      .in_control(cur.ctrl), .in_compflg(cur.cf), .in_program_counter(cur.pc),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .data1(data1), .data2(data2), .immediate_data(immediate_data),
      .program_counter(program_counter), .control_in(control_in),
      .compflg_in(compflg_in), .stall_cycles(stall16)
   );
   decode_execute_reg #(.CTRL_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
      .in_data1(cur.d1), .in_data2(cur.d2), .in_immediate_data(cur.imm),
      .in_control(cur.ctrl), .in_compflg(cur.cf), .in_program_counter(cur.pc),
      .flush(flush), .out_valid(ov4), .out_ready(out_ready),
      .data1(d1_4), .data2(d2_4), .immediate_data(imm_4),
      .program_counter(pc4), .control_in(ctrl4),
      .compflg_in(cf4), .stall_cycles(stall4)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic instr_t rnd(input logic [31:0] pc);
      instr_t t;
      t.d1 = $urandom; t.d2 = $urandom; t.imm = $urandom; t.ctrl = $urandom;
      t.cf = 1'($urandom_range(0, 1)); t.pc = pc;
      return t;
   endfunction
   task automatic check_all();
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid4", ov4, q.size() > 0);
      chk("stall16", stall16, cnt > 65535 ? 65535 : cnt);
      chk("stall4", stall4, cnt > 15 ? 15 : cnt);
      if (q.size() > 0) begin
         chk("pc", program_counter, q[0].pc);
         chk("data1", data1, q[0].d1);
         chk("data2", data2, q[0].d2);
         chk("imm", immediate_data, q[0].imm);
         chk("ctrl", control_in, q[0].ctrl);
         chk("compflg", compflg_in, q[0].cf);
         chk("pc4", pc4, q[0].pc);
      end
   endtask
   // FIFO of at most two instructions; the head is what execute should see
   task automatic tick();
      instr_t nq[$];
      int nc;
      nq = q;
      nc = cnt;
      if (rst) begin
         nq.delete();
         nc = 0;
      end else begin
         if (q.size() > 0 && !out_ready) nc++;
         if (flush) nq.delete();
         else begin
            if (q.size() > 0 && out_ready) nq.delete(0);
            if (in_valid && q.size() < 2) nq.push_back(cur);
         end
      end
      @(posedge clk);
      #1;
      q = nq;
      cnt = nc;
      check_all();
   endtask
   initial begin
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_ctrl", control_in, 0);
      chk("rst_stall", stall16, 0);
      rst = 1'b0;
      repeat (3) tick();
      chk("idle_out_valid", out_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cur = rnd(32'(4 * i));
         in_valid = 1'b1;
         tick();
         chk("stream_pc", program_counter, 32'(4 * i));
         chk("stream_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", out_valid, 0);
      chk("stream_stall", stall16, 0);
      out_ready = 1'b0;
      cur = rnd(32'h100); in_valid = 1'b1; tick();
      cur = rnd(32'h104); tick();
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'b0;
      repeat (3) tick();
      chk("bp_hold_pc", program_counter, 32'h100);
      out_ready = 1'b1;
      tick();
      chk("bp_second_pc", program_counter, 32'h104);
      chk("bp_stall", stall16, 4);
      tick();
      chk("bp_drain", out_valid, 0);
      out_ready = 1'b0;
      cur = rnd(32'h200); in_valid = 1'b1; tick();
      cur = rnd(32'h204); tick();
      cur = rnd(32'h208); flush = 1'b1; tick();
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      chk("flush_ctrl", control_in, 0);
      flush = 1'b0;
      cur = rnd(32'h300); out_ready = 1'b1; tick();
      chk("post_flush_pc", program_counter, 32'h300);
      in_valid = 1'b0; tick();
      chk("post_flush_drain", out_valid, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0;
      cur = rnd(32'h400); in_valid = 1'b1; tick();
      in_valid = 1'b0;
      repeat (20) tick();
      chk("sat4", stall4, 15);
      chk("sat16", stall16, 20);
      cur = rnd(32'h500); in_valid = 1'b1; tick();
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_ctrl", control_in, 0);
      chk("arst_stall", stall16, 0);
      q.delete();
      cnt = 0;
      rst = 1'b0;
      check_all();
      for (int i = 0; i < 400; i++) begin
         cur = rnd(32'h1000 + 32'(4 * i));
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 15) == 0;
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
